regfile_sb: RTL

Parametrised integer register file for the core's decode/writeback stages: two asynchronous read ports, one synchronous write port, register 0 hardwired to zero, optional write-to-read bypass, and a per-register scoreboard of pending writes. It replaces the fixed 32x32 register file and lets decode detect read-after-write hazards without extra pipeline logic.

---
 rtl/regfile_sb.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Integer register file with two async read ports, one sync write port, x0 hardwired to zero,
// optional write-to-read bypass and a per-register scoreboard of pending writes.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned AW     = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [AW-1:0]   read1,
    input  logic [AW-1:0]   read2,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2,
    output logic            busy1,
    output logic            busy2,
    input  logic [AW-1:0]   write1,
    input  logic [XLEN-1:0] write_data,
    input  logic            regwrite,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            any_busy
);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] sb;

    logic wr_en;
    logic iss_en;

    assign wr_en  = regwrite && (write1 != '0);
    assign iss_en = iss_valid && (iss_rd != '0);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            sb <= '0;
        end else begin
            if (wr_en) begin
                rf[write1] <= write_data;
                sb[write1] <= 1'b0;
            end
            // A new producer supersedes the retiring one, so the set is applied last.
            if (iss_en) begin
                sb[iss_rd] <= 1'b1;
            end
        end
    end

    logic byp1;
    logic byp2;

    // Bypass is gated by reset so a pending writeback cannot leak out while the file is cleared.
    assign byp1 = BYPASS && reset && wr_en && (write1 == read1);
    assign byp2 = BYPASS && reset && wr_en && (write1 == read2);

    always_comb begin
        out1  = rf[read1];
        busy1 = sb[read1];
        if (byp1) begin
            out1  = write_data;
            busy1 = 1'b0;
        end
        if (!reset || (read1 == '0)) begin
            out1  = '0;
            busy1 = 1'b0;
        end
    end

    always_comb begin
        out2  = rf[read2];
        busy2 = sb[read2];
        if (byp2) begin
            out2  = write_data;
            busy2 = 1'b0;
        end
        if (!reset || (read2 == '0)) begin
            out2  = '0;
            busy2 = 1'b0;
        end
    end

    assign any_busy = reset && (|sb);

endmodule
